// File: rtl/watch_button_ctrl_if.sv
// Button-to-controller bundle: raw board buttons in, conditioned watch commands out.
interface watch_button_ctrl_if;
  logic       btnMode;
  logic       btnReset;
  logic       btnSet;
  logic       btnUp;
  logic       btnNext;
  logic       btnStart;
  logic       btnStop;
  logic [2:0] mode;
  logic       resetTime;
  logic       setValue;
  logic       upTime;
  logic       nextDigit;
  logic       start_resume;
  logic       stop;

  modport master (
    output btnMode, btnReset, btnSet, btnUp, btnNext, btnStart, btnStop,
    input  mode, resetTime, setValue, upTime, nextDigit, start_resume, stop
  );

  modport slave (
    input  btnMode, btnReset, btnSet, btnUp, btnNext, btnStart, btnStop,
    output mode, resetTime, setValue, upTime, nextDigit, start_resume, stop
  );
endinterface

// File: rtl/watch_button_ctrl.sv
// Button conditioner: synchronise, debounce and edge-detect seven buttons, then
// turn presses into registered command pulses, a wrapping mode and up auto-repeat.
module watch_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 4,
  parameter int NUM_MODES       = 5
) (
  input logic                clk,
  input logic                reset,
  watch_button_ctrl_if.slave bus
);

  localparam int NB      = 7;
  localparam int B_MODE  = 0;
  localparam int B_RST   = 1;
  localparam int B_SET   = 2;
  localparam int B_UP    = 3;
  localparam int B_NEXT  = 4;
  localparam int B_START = 5;
  localparam int B_STOP  = 6;

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DLY_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] RATE_LAST = TMR_W'(REPEAT_RATE - 1);
  localparam logic [2:0]       MODE_LAST = 3'(NUM_MODES - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync_p0;
  logic [NB-1:0]    sync_p1;
  logic [NB-1:0]    stable;
  logic [NB-1:0]    stable_q;
  logic [CNT_W-1:0] cnt [NB];

  rpt_state_t       state;
  logic [TMR_W-1:0] timer;
  logic [2:0]       mode_q;
  logic             set_q;
  logic             up_q;
  logic             next_q;
  logic             start_q;
  logic             stop_q;

  logic press_mode;
  logic press_set;
  logic press_up;
  logic press_next;
  logic press_start;
  logic press_stop;

  assign raw = {bus.btnStop, bus.btnStart, bus.btnNext, bus.btnUp,
                bus.btnSet, bus.btnReset, bus.btnMode};

  assign press_mode  = stable[B_MODE]  & ~stable_q[B_MODE];
  assign press_set   = stable[B_SET]   & ~stable_q[B_SET];
  assign press_up    = stable[B_UP]    & ~stable_q[B_UP];
  assign press_next  = stable[B_NEXT]  & ~stable_q[B_NEXT];
  assign press_start = stable[B_START] & ~stable_q[B_START];
  assign press_stop  = stable[B_STOP]  & ~stable_q[B_STOP];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
      state    <= IDLE;
      timer    <= '0;
      mode_q   <= '0;
      set_q    <= 1'b0;
      up_q     <= 1'b0;
      next_q   <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      // stage p0/p1: two-flop synchroniser, then debounce against the accepted level
      sync_p0  <= raw;
      sync_p1  <= sync_p0;
      stable_q <= stable;
      for (int i = 0; i < NB; i++) begin
        if (sync_p1[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync_p1[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end

      // stage p2: registered commands; a mode press wins over set/up/next, stop over start
      if (press_mode) mode_q <= (mode_q == MODE_LAST) ? 3'd0 : mode_q + 3'd1;
      set_q   <= press_set  & ~press_mode;
      next_q  <= press_next & ~press_mode;
      stop_q  <= press_stop;
      start_q <= press_start & ~press_stop;

      up_q <= 1'b0;
      if (press_mode) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (press_up) begin
              up_q  <= 1'b1;
              state <= DELAY;
              timer <= '0;
            end
          end
          DELAY: begin
            if (!stable[B_UP]) begin
              state <= IDLE;
            end else if (timer == DLY_LAST) begin
              up_q  <= 1'b1;
              state <= REPEAT;
              timer <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          REPEAT: begin
            if (!stable[B_UP]) begin
              state <= IDLE;
            end else if (timer == RATE_LAST) begin
              up_q  <= 1'b1;
              timer <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.mode         = mode_q;
  assign bus.resetTime    = stable_q[B_RST];
  assign bus.setValue     = set_q;
  assign bus.upTime       = up_q;
  assign bus.nextDigit    = next_q;
  assign bus.start_resume = start_q;
  assign bus.stop         = stop_q;

endmodule

// File: doc/watch_button_ctrl.md
Name: watch_button_ctrl

Overview:
Front-end input conditioner that generates the control interface consumed by the watch controller: mode select, resetTime, setValue, upTime, nextDigit, start_resume and stop.
- Takes raw, bouncing, asynchronous push-button levels.
- Synchronises, debounces and edge-detects each button.
- Produces registered one-cycle command pulses, a wrapping mode register, and auto-repeat on the up button.
- Sits between the board buttons and the watch controller's input ports.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a new level must hold before it is accepted (>=2)
REPEAT_DELAY, 16, cycles after the upTime press pulse before auto-repeat starts
REPEAT_RATE, 4, cycles between auto-repeat upTime pulses (>=2)
NUM_MODES, 5, number of modes; mode counts 0..NUM_MODES-1 (<=8)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
btnMode  input  1  raw mode button, active high, asynchronous
btnReset  input  1  raw time-reset button
btnSet  input  1  raw set button
btnUp  input  1  raw up button
btnNext  input  1  raw next-digit button
btnStart  input  1  raw start/resume button
btnStop  input  1  raw stop button
mode  output  3  current mode, registered
resetTime  output  1  debounced level of btnReset, registered
setValue  output  1  one-cycle pulse per accepted set press
upTime  output  1  one-cycle pulse per up press, plus auto-repeat pulses
nextDigit  output  1  one-cycle pulse per accepted next press
start_resume  output  1  one-cycle pulse per accepted start press
stop  output  1  one-cycle pulse per accepted stop press

Behaviour:
- Reset (synchronous, any time, including mid-debounce or mid-repeat) clears every synchroniser, debounce counter, stable level, edge register, repeat FSM and output. All outputs are 0 and mode=0 in the cycle after the reset edge.
- Per button, identical channel:
  - 2-flop synchroniser s1->s2.
  - Counter cnt counts cycles where s2 != stable; cnt clears to 0 on any cycle where s2 == stable.
  - When s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes stable.
- Press event = stable rising; it is registered, so the output pulse is high for exactly 1 cycle.
- Latency: raw rises before edge n and stays high -> stable rises at edge n+1+DEBOUNCE_CYCLES -> pulse output high for the cycle following edge n+2+DEBOUNCE_CYCLES (edge n+6 at default).
- Release is debounced identically and generates no pulse.
- resetTime = registered stable level of btnReset; same n+2+DEBOUNCE_CYCLES latency; held high while the button is held.
- mode: on a mode press event, mode <= (mode == NUM_MODES-1) ? 0 : mode+1. Updates in the same cycle the pulse would appear.
- Up auto-repeat FSM:
  - States: IDLE, DELAY, REPEAT.
  - IDLE: on up press event, emit upTime, go to DELAY, timer=0.
  - DELAY: timer increments each cycle. At timer == REPEAT_DELAY-1, emit upTime, go to REPEAT, timer=0.
  - REPEAT: at timer == REPEAT_RATE-1, emit upTime, timer=0.
  - DELAY or REPEAT: up stable level falls -> IDLE immediately, no pulse that cycle.
  - Mode press event in any state -> IDLE, no upTime that cycle.
- Simultaneous events in the same cycle:
  - start and stop both pressed: stop pulses, start_resume is suppressed (dropped, not deferred).
  - Mode press together with set/up/next press: mode advances; setValue, upTime and nextDigit are suppressed that cycle.
  - Any other combination: all pulses pass independently.
- Pulse spacing: one pulse per press. A held button (other than up) never re-pulses. Minimum spacing between two press pulses of one button is 2*DEBOUNCE_CYCLES cycles.
- Widths: debounce counters are ceil(log2(DEBOUNCE_CYCLES)) bits; the repeat timer is sized for max(REPEAT_DELAY, REPEAT_RATE). Counters saturate/clear, never wrap.

Test Plan:
1. Reset=1 for 3 cycles with all buttons high -> all outputs 0, mode=0; after release, no pulse appears until 2+DEBOUNCE_CYCLES cycles of stable input.
2. btnSet high from before edge 10, held 20 cycles -> setValue high exactly during the cycle after edge 16; no further pulse on hold or release.
3. btnNext bounce 1,0,1,0 (1 cycle each), then steady 1 -> no pulse during bounce; exactly one nextDigit pulse 6 edges after the last 0->1 raw transition.
4. Five mode presses (each held 10, released 10) -> mode sequence 1,2,3,4,0; a sixth press -> 1.
5. btnUp held 40 cycles -> upTime pulses at first press (P), P+16, P+20, P+24, ...; count = 1+1+floor((remaining held cycles)/4); release -> no pulse within 2 cycles of stable fall.
6. btnStart and btnStop rise on the same edge -> single stop pulse, start_resume stays 0; reset asserted mid-auto-repeat -> upTime 0 next cycle, FSM IDLE, mode=0.
